// File: rtl/ctrl_pipe_pkg.sv
// Shared encodings, control bundle type and decode defaults for the ID stage.
package ctrl_pipe_pkg;

  localparam int unsigned CPU_WIDTH        = 32;
  localparam int unsigned REG_ADDR_WIDTH   = 5;
  localparam int unsigned ALU_OP_WIDTH     = 5;
  localparam int unsigned MEM_OP_WIDTH     = 3;
  localparam int unsigned IMM_GEN_OP_WIDTH = 3;
  localparam int unsigned ALU_SRC_WIDTH    = 2;

  localparam logic [6:0] OPCODE_LUI   = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL   = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR  = 7'b1100111;
  localparam logic [6:0] OPCODE_B     = 7'b1100011;
  localparam logic [6:0] OPCODE_IL    = 7'b0000011;
  localparam logic [6:0] OPCODE_S     = 7'b0100011;
  localparam logic [6:0] OPCODE_I     = 7'b0010011;
  localparam logic [6:0] OPCODE_R     = 7'b0110011;

  localparam logic [6:0] FUNCT7_INST_A = 7'b0000000;
  localparam logic [6:0] FUNCT7_INST_B = 7'b0100000;
  localparam logic [6:0] FUNCT7_INST_M = 7'b0000001;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_AND    = 5'd0,
    ALU_OR     = 5'd1,
    ALU_XOR    = 5'd2,
    ALU_ADD    = 5'd3,
    ALU_SUB    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_BEQ    = 5'd10,
    ALU_BNE    = 5'd11,
    ALU_BLT    = 5'd12,
    ALU_BGE    = 5'd13,
    ALU_BLTU   = 5'd14,
    ALU_BGEU   = 5'd15,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_op_e;

  typedef enum logic {ALU2REG = 1'b0, MEM2REG = 1'b1} mem2reg_e;

  typedef enum logic [MEM_OP_WIDTH-1:0] {
    MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_op_e;

  typedef enum logic [IMM_GEN_OP_WIDTH-1:0] {
    IMM_GEN_I, IMM_GEN_S, IMM_GEN_B, IMM_GEN_U, IMM_GEN_J
  } imm_gen_e;

  typedef enum logic [ALU_SRC_WIDTH-1:0] {
    ALU_SRC_REG, ALU_SRC_IMM, ALU_SRC_FOUR_PC, ALU_SRC_IMM_PC
  } alu_src_e;

  typedef struct packed {
    logic                      branch;
    logic                      jump;
    logic                      reg_wen;
    logic [REG_ADDR_WIDTH-1:0] reg_waddr;
    logic [REG_ADDR_WIDTH-1:0] reg1_raddr;
    logic [REG_ADDR_WIDTH-1:0] reg2_raddr;
    logic                      mem_wen;
    logic                      mem_ren;
    mem2reg_e                  mem2reg;
    mem_op_e                   mem_op;
    imm_gen_e                  imm_gen_op;
    alu_op_e                   alu_op;
    alu_src_e                  alu_src_sel;
    logic                      illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_DEFAULT = '{
    branch:      1'b0,
    jump:        1'b0,
    reg_wen:     1'b0,
    reg_waddr:   '0,
    reg1_raddr:  '0,
    reg2_raddr:  '0,
    mem_wen:     1'b0,
    mem_ren:     1'b0,
    mem2reg:     ALU2REG,
    mem_op:      MEM_LW,
    imm_gen_op:  IMM_GEN_I,
    alu_op:      ALU_AND,
    alu_src_sel: ALU_SRC_REG,
    illegal:     1'b0
  };

  // Shared by OP and OP-IMM; alt selects SUB/SRA where the encoding allows it.
  function automatic alu_op_e alu_base_op(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl_pipe_dec.sv
// Combinational RV32I(+M) decode: control bundle, illegal flag and operand-use flags.
module ctrl_dec
  import ctrl_pipe_pkg::*;
#(
  parameter bit EN_M_EXT = 1'b0
) (
  input  logic [CPU_WIDTH-1:0] inst,
  output ctrl_t                ctrl,
  output logic                 uses_rs1,
  output logic                 uses_rs2
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       ill;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign funct7 = inst[31:25];

  always_comb begin
    ctrl     = CTRL_DEFAULT;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    ill      = 1'b0;
    case (opcode)
      OPCODE_LUI: begin
        ctrl.reg_wen     = 1'b1;
        ctrl.reg_waddr   = rd;
        ctrl.imm_gen_op  = IMM_GEN_U;
        ctrl.alu_op      = ALU_ADD;
        ctrl.alu_src_sel = ALU_SRC_IMM;
      end
      OPCODE_AUIPC: begin
        ctrl.reg_wen     = 1'b1;
        ctrl.reg_waddr   = rd;
        ctrl.imm_gen_op  = IMM_GEN_U;
        ctrl.alu_op      = ALU_ADD;
        ctrl.alu_src_sel = ALU_SRC_IMM_PC;
      end
      OPCODE_JAL: begin
        ctrl.jump        = 1'b1;
        ctrl.reg_wen     = 1'b1;
        ctrl.reg_waddr   = rd;
        ctrl.imm_gen_op  = IMM_GEN_J;
        ctrl.alu_op      = ALU_ADD;
        ctrl.alu_src_sel = ALU_SRC_FOUR_PC;
      end
      OPCODE_JALR: begin
        uses_rs1         = 1'b1;
        ctrl.jump        = 1'b1;
        ctrl.reg_wen     = 1'b1;
        ctrl.reg_waddr   = rd;
        ctrl.reg1_raddr  = rs1;
        ctrl.imm_gen_op  = IMM_GEN_I;
        ctrl.alu_op      = ALU_ADD;
        ctrl.alu_src_sel = ALU_SRC_FOUR_PC;
      end
      OPCODE_B: begin
        uses_rs1        = 1'b1;
        uses_rs2        = 1'b1;
        ctrl.branch     = 1'b1;
        ctrl.reg1_raddr = rs1;
        ctrl.reg2_raddr = rs2;
        ctrl.imm_gen_op = IMM_GEN_B;
        case (funct3)
          3'b000:  ctrl.alu_op = ALU_BEQ;
          3'b001:  ctrl.alu_op = ALU_BNE;
          3'b100:  ctrl.alu_op = ALU_BLT;
          3'b101:  ctrl.alu_op = ALU_BGE;
          3'b110:  ctrl.alu_op = ALU_BLTU;
          3'b111:  ctrl.alu_op = ALU_BGEU;
          default: ill = 1'b1;
        endcase
      end
      OPCODE_IL: begin
        uses_rs1         = 1'b1;
        ctrl.mem_ren     = 1'b1;
        ctrl.reg_wen     = 1'b1;
        ctrl.reg_waddr   = rd;
        ctrl.reg1_raddr  = rs1;
        ctrl.mem2reg     = MEM2REG;
        ctrl.imm_gen_op  = IMM_GEN_I;
        ctrl.alu_op      = ALU_ADD;
        ctrl.alu_src_sel = ALU_SRC_IMM;
        case (funct3)
          3'b000:  ctrl.mem_op = MEM_LB;
          3'b001:  ctrl.mem_op = MEM_LH;
          3'b010:  ctrl.mem_op = MEM_LW;
          3'b100:  ctrl.mem_op = MEM_LBU;
          3'b101:  ctrl.mem_op = MEM_LHU;
          default: ill = 1'b1;
        endcase
      end
      OPCODE_S: begin
        uses_rs1         = 1'b1;
        uses_rs2         = 1'b1;
        ctrl.mem_wen     = 1'b1;
        ctrl.reg1_raddr  = rs1;
        ctrl.reg2_raddr  = rs2;
        ctrl.imm_gen_op  = IMM_GEN_S;
        ctrl.alu_op      = ALU_ADD;
        ctrl.alu_src_sel = ALU_SRC_IMM;
        case (funct3)
          3'b000:  ctrl.mem_op = MEM_SB;
          3'b001:  ctrl.mem_op = MEM_SH;
          3'b010:  ctrl.mem_op = MEM_SW;
          default: ill = 1'b1;
        endcase
      end
      OPCODE_I: begin
        uses_rs1         = 1'b1;
        ctrl.reg_wen     = 1'b1;
        ctrl.reg_waddr   = rd;
        ctrl.reg1_raddr  = rs1;
        ctrl.imm_gen_op  = IMM_GEN_I;
        ctrl.alu_src_sel = ALU_SRC_IMM;
        // inst[30] is immediate data except for the SRAI shift-type bit
        ctrl.alu_op      = alu_base_op(funct3, (funct3 == F3_SRL_SRA) && inst[30]);
      end
      OPCODE_R: begin
        uses_rs1         = 1'b1;
        uses_rs2         = 1'b1;
        ctrl.reg_wen     = 1'b1;
        ctrl.reg_waddr   = rd;
        ctrl.reg1_raddr  = rs1;
        ctrl.reg2_raddr  = rs2;
        ctrl.alu_src_sel = ALU_SRC_REG;
        case (funct7)
          FUNCT7_INST_A: ctrl.alu_op = alu_base_op(funct3, 1'b0);
          FUNCT7_INST_B: begin
            if (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA)
              ctrl.alu_op = alu_base_op(funct3, 1'b1);
            else
              ill = 1'b1;
          end
          FUNCT7_INST_M: begin
            if (EN_M_EXT)
              ctrl.alu_op = alu_op_e'(5'(ALU_MUL) + 5'(funct3));
            else
              ill = 1'b1;
          end
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      ctrl         = CTRL_DEFAULT;
      ctrl.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ID-stage pipeline register around ctrl_dec with valid/ready handshake,
// load-use interlock, flush and a saturating interlock stall counter.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter bit          EN_M_EXT  = 1'b0,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CPU_WIDTH-1:0]        inst,
  input  logic [CPU_WIDTH-1:0]        in_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CPU_WIDTH-1:0]        out_pc,
  output logic                        branch,
  output logic                        jump,
  output logic                        reg_wen,
  output logic [REG_ADDR_WIDTH-1:0]   reg_waddr,
  output logic [REG_ADDR_WIDTH-1:0]   reg1_raddr,
  output logic [REG_ADDR_WIDTH-1:0]   reg2_raddr,
  output logic                        mem_wen,
  output logic                        mem_ren,
  output logic                        mem2reg,
  output logic [MEM_OP_WIDTH-1:0]     mem_op,
  output logic [IMM_GEN_OP_WIDTH-1:0] imm_gen_op,
  output logic [ALU_OP_WIDTH-1:0]     alu_op,
  output logic [ALU_SRC_WIDTH-1:0]    alu_src_sel,
  output logic                        illegal,
  output logic [CNT_WIDTH-1:0]        stall_cnt
);

  ctrl_t dec;
  ctrl_t q;
  logic  uses_rs1;
  logic  uses_rs2;
  logic  hz;
  logic  accept;

  ctrl_dec #(.EN_M_EXT(EN_M_EXT)) u_dec (
    .inst     (inst),
    .ctrl     (dec),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  // Raw rs fields are compared; uses_rs* masks encodings where they are immediate bits.
  always_comb begin
    hz = out_valid && q.mem_ren && !q.mem_wen && (q.reg_waddr != '0) &&
         ((uses_rs1 && (inst[19:15] == q.reg_waddr)) ||
          (uses_rs2 && (inst[24:20] == q.reg_waddr)));
    in_ready = !flush && !hz && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      q         <= CTRL_DEFAULT;
      stall_cnt <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_pc    <= in_pc;
        q         <= dec;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (hz && in_valid && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_comb begin
    branch      = q.branch;
    jump        = q.jump;
    reg_wen     = q.reg_wen;
    reg_waddr   = q.reg_waddr;
    reg1_raddr  = q.reg1_raddr;
    reg2_raddr  = q.reg2_raddr;
    mem_wen     = q.mem_wen;
    mem_ren     = q.mem_ren;
    mem2reg     = q.mem2reg;
    mem_op      = q.mem_op;
    imm_gen_op  = q.imm_gen_op;
    alu_op      = q.alu_op;
    alu_src_sel = q.alu_src_sel;
    illegal     = q.illegal;
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe: instance a has M enabled, instance b has M disabled and a 2-bit counter.
module tb_ctrl_pipe;
  import ctrl_pipe_pkg::*;

  localparam logic [31:0] I_ADDI  = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] I_LW    = 32'h0000A103; // lw x2,0(x1)
  localparam logic [31:0] I_ADD   = 32'h001101B3; // add x3,x2,x1
  localparam logic [31:0] I_ADD4  = 32'h00208233; // add x4,x1,x2
  localparam logic [31:0] I_ADDI2 = 32'h00A00113; // addi x2,x0,10

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [31:0] inst, in_pc;

  logic        in_ready, out_valid, branch, jump, reg_wen, mem_wen, mem_ren, mem2reg, illegal;
  logic [31:0] out_pc;
  logic [4:0]  reg_waddr, reg1_raddr, reg2_raddr, alu_op;
  logic [2:0]  mem_op, imm_gen_op;
  logic [1:0]  alu_src_sel;
  logic [15:0] stall_cnt;

  logic        b_in_ready, b_out_valid, b_branch, b_jump, b_reg_wen, b_mem_wen, b_mem_ren, b_mem2reg, b_illegal;
  logic [31:0] b_out_pc;
  logic [4:0]  b_reg_waddr, b_reg1_raddr, b_reg2_raddr, b_alu_op;
  logic [2:0]  b_mem_op, b_imm_gen_op;
  logic [1:0]  b_alu_src_sel;
  logic [1:0]  b_stall_cnt;

  int errors = 0;
  int checks = 0;

  ctrl_pipe #(.EN_M_EXT(1'b1), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .branch(branch), .jump(jump), .reg_wen(reg_wen), .reg_waddr(reg_waddr),
    .reg1_raddr(reg1_raddr), .reg2_raddr(reg2_raddr), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem2reg(mem2reg), .mem_op(mem_op), .imm_gen_op(imm_gen_op), .alu_op(alu_op),
    .alu_src_sel(alu_src_sel), .illegal(illegal), .stall_cnt(stall_cnt)
  );

  ctrl_pipe #(.EN_M_EXT(1'b0), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .inst(inst), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
    .branch(b_branch), .jump(b_jump), .reg_wen(b_reg_wen), .reg_waddr(b_reg_waddr),
    .reg1_raddr(b_reg1_raddr), .reg2_raddr(b_reg2_raddr), .mem_wen(b_mem_wen), .mem_ren(b_mem_ren),
    .mem2reg(b_mem2reg), .mem_op(b_mem_op), .imm_gen_op(b_imm_gen_op), .alu_op(b_alu_op),
    .alu_src_sel(b_alu_src_sel), .illegal(b_illegal), .stall_cnt(b_stall_cnt)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    inst = I_ADDI; in_pc = 32'h40;
    cyc(); cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
    checks++; if (b_stall_cnt !== 2'd0) begin errors++; $display("FAIL reset_b_stall_cnt got=%0d exp=0", b_stall_cnt); end
    checks++; if (out_pc !== 32'd0) begin errors++; $display("FAIL reset_out_pc got=%0h exp=0", out_pc); end
    checks++; if (alu_op !== ALU_AND) begin errors++; $display("FAIL reset_alu_op got=%0d exp=%0d", alu_op, ALU_AND); end
    checks++; if (mem_op !== MEM_LW) begin errors++; $display("FAIL reset_mem_op got=%0d exp=%0d", mem_op, MEM_LW); end
    checks++; if ({illegal, reg_wen, mem_ren, mem_wen} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {illegal, reg_wen, mem_ren, mem_wen}); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL addi_in_ready got=%0h exp=1", in_ready); end
    cyc();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_out_valid got=%0h exp=1", out_valid); end
    checks++; if (reg_wen !== 1'b1 || reg_waddr !== 5'd1) begin errors++; $display("FAIL addi_rd got wen=%0h rd=%0d exp wen=1 rd=1", reg_wen, reg_waddr); end
    checks++; if (alu_op !== ALU_ADD) begin errors++; $display("FAIL addi_alu_op got=%0d exp=%0d", alu_op, ALU_ADD); end
    checks++; if (alu_src_sel !== ALU_SRC_IMM) begin errors++; $display("FAIL addi_alu_src got=%0d exp=%0d", alu_src_sel, ALU_SRC_IMM); end
    checks++; if (out_pc !== 32'h40) begin errors++; $display("FAIL addi_out_pc got=%0h exp=40", out_pc); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain got=%0h exp=0", out_valid); end
  endtask

  task automatic test_load_use();
    in_valid = 1'b1; out_ready = 1'b1; inst = I_LW; in_pc = 32'h100;
    cyc();
    inst = I_ADD; in_pc = 32'h104;
    #1;
    checks++; if (out_valid !== 1'b1 || mem_ren !== 1'b1 || reg_waddr !== 5'd2) begin errors++; $display("FAIL lw_out got v=%0h ren=%0h rd=%0d exp 1 1 2", out_valid, mem_ren, reg_waddr); end
    checks++; if (mem2reg !== MEM2REG) begin errors++; $display("FAIL lw_mem2reg got=%0h exp=1", mem2reg); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lu_in_ready_stall got=%0h exp=0", in_ready); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got=%0h exp=0", out_valid); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lu_in_ready_after got=%0h exp=1", in_ready); end
    cyc();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h104) begin errors++; $display("FAIL lu_add_out got v=%0h pc=%0h exp v=1 pc=104", out_valid, out_pc); end
    checks++; if (reg_waddr !== 5'd3 || reg1_raddr !== 5'd2 || reg2_raddr !== 5'd1) begin errors++; $display("FAIL lu_add_regs got rd=%0d rs1=%0d rs2=%0d exp 3 2 1", reg_waddr, reg1_raddr, reg2_raddr); end
    checks++; if (alu_op !== ALU_ADD || stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_add_op got op=%0d cnt=%0d exp op=%0d cnt=1", alu_op, stall_cnt, ALU_ADD); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; inst = I_ADD4; in_pc = 32'h108;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%0h exp=0", i, in_ready); end
      cyc();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h104 || reg_waddr !== 5'd3) begin errors++; $display("FAIL bp_hold[%0d] got v=%0h pc=%0h rd=%0d exp 1 104 3", i, out_valid, out_pc, reg_waddr); end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%0h exp=1", in_ready); end
    cyc();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h108 || reg_waddr !== 5'd4) begin errors++; $display("FAIL bp_next got v=%0h pc=%0h rd=%0d exp 1 108 4", out_valid, out_pc, reg_waddr); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got=%0h exp=0", out_valid); end
  endtask

  task automatic test_back_to_back_m_ext();
    logic [31:0] tbl [3] = '{32'h022081B3, 32'h0220B1B3, 32'h0220F1B3};
    logic [4:0]  exp [3] = '{ALU_MUL, ALU_MULHU, ALU_REMU};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; inst = tbl[i]; in_pc = 32'h200 + 32'(4 * i);
      cyc();
      checks++; if (alu_op !== exp[i] || illegal !== 1'b0) begin errors++; $display("FAIL m_op[%0d] got op=%0d ill=%0h exp op=%0d ill=0", i, alu_op, illegal, exp[i]); end
      checks++; if (reg_wen !== 1'b1 || reg_waddr !== 5'd3 || out_pc !== 32'h200 + 32'(4 * i)) begin errors++; $display("FAIL m_wb[%0d] got wen=%0h rd=%0d pc=%0h", i, reg_wen, reg_waddr, out_pc); end
      checks++; if (b_out_valid !== 1'b1 || b_illegal !== 1'b1 || b_reg_wen !== 1'b0) begin errors++; $display("FAIL m_disabled[%0d] got v=%0h ill=%0h wen=%0h exp 1 1 0", i, b_out_valid, b_illegal, b_reg_wen); end
    end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_illegal();
    logic [31:0] tbl [4] = '{32'hFFFFFFFF, 32'h0000B103, 32'h401091B3, 32'h401081B3};
    logic        exp [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; inst = tbl[i]; in_pc = 32'h280;
      cyc();
      checks++; if (illegal !== exp[i] || out_valid !== 1'b1) begin errors++; $display("FAIL ill_flag[%0d] got ill=%0h v=%0h exp ill=%0h v=1", i, illegal, out_valid, exp[i]); end
      if (exp[i]) begin
        checks++; if ({reg_wen, mem_wen, mem_ren, branch, jump} !== 5'b0) begin errors++; $display("FAIL ill_enables[%0d] got=%b exp=00000", i, {reg_wen, mem_wen, mem_ren, branch, jump}); end
      end else begin
        checks++; if (alu_op !== ALU_SUB || reg_wen !== 1'b1) begin errors++; $display("FAIL sub_decode got op=%0d wen=%0h exp op=%0d wen=1", alu_op, reg_wen, ALU_SUB); end
      end
    end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_flush();
    in_valid = 1'b1; out_ready = 1'b1; inst = I_ADDI; in_pc = 32'h300;
    cyc();
    out_ready = 1'b0; flush = 1'b1; inst = I_ADDI2; in_pc = 32'h304;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%0h exp=0", in_ready); end
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%0h exp=0", out_valid); end
    checks++; if (out_pc !== 32'h300) begin errors++; $display("FAIL flush_no_accept got pc=%0h exp=300", out_pc); end
    in_valid = 1'b1; out_ready = 1'b1; inst = I_LW; in_pc = 32'h310;
    cyc();
    inst = I_ADD; in_pc = 32'h314; out_ready = 1'b0;
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (stall_cnt !== 16'd2 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_hz got cnt=%0d v=%0h exp cnt=2 v=0", stall_cnt, out_valid); end
  endtask

  task automatic test_saturation();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    rst = 1'b0;
    checks++; if (b_stall_cnt !== 2'd0 || stall_cnt !== 16'd0) begin errors++; $display("FAIL sat_reset got b=%0d a=%0d exp 0 0", b_stall_cnt, stall_cnt); end
    in_valid = 1'b1; inst = I_LW; in_pc = 32'h400;
    cyc();
    inst = I_ADD; in_pc = 32'h404; out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      int exp_cnt;
      exp_cnt = (k > 3) ? 3 : k;
      cyc();
      checks++; if (b_stall_cnt !== 2'(exp_cnt) || b_out_valid !== 1'b1) begin errors++; $display("FAIL sat_cnt[%0d] got cnt=%0d v=%0h exp cnt=%0d v=1", k, b_stall_cnt, b_out_valid, exp_cnt); end
    end
    checks++; if (stall_cnt !== 16'd6 || b_in_ready !== 1'b0) begin errors++; $display("FAIL sat_wide got cnt=%0d rdy=%0h exp cnt=6 rdy=0", stall_cnt, b_in_ready); end
    rst = 1'b1;
    cyc();
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (stall_cnt !== 16'd0 || b_stall_cnt !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_stall got a=%0d b=%0d v=%0h exp 0 0 0", stall_cnt, b_stall_cnt, out_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_backpressure();
    test_back_to_back_m_ext();
    test_illegal();
    test_flush();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
